// File: rtl/tdm_pkg.sv
// Shared types and limits for the 2:1 TDM receive path.
package tdm_pkg;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   typedef enum logic {IDLE, RECV} state_t;
   typedef enum logic {SLOT_A, SLOT_B} slot_t;

endpackage

// File: rtl/tdm_lane_shift.sv
// One channel's deserialiser: shift register with clear and shift-enable.
module tdm_lane_shift #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH-1:0] base;

   // Clear and shift may coincide: the first bit of a new frame lands in an emptied register.
   // NOTE: every always_comb output gets a default first, so no latch can be inferred.
   always_comb begin
      base   = clear ? '0 : q;
      q_next = base;
      if (shift_en) begin
         if (MSB_FIRST) q_next = {base[WIDTH-2:0], din};
         else           q_next = {din, base[WIDTH-1:1]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= q_next;
   end

endmodule

// File: rtl/tdm_demux2_rx.sv
// Splits an A,B-interleaved serial frame into two words with a valid/ready output stage.
module tdm_demux2_rx
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned CW = $clog2(2 * WIDTH);
   localparam logic [CW-1:0] LAST_SLOT = CW'(2 * WIDTH - 1);

   state_t          state;
   logic [CW-1:0]   slot_cnt;
   slot_t           slot;
   logic            start;
   logic            take;
   logic            last;
   logic [WIDTH-1:0] a_q, a_next, b_q, b_next;

   // A sync with a valid slot restarts the frame in any state; that slot is A bit 0.
   assign start = din_valid && sync;
   assign take  = din_valid && (start || state == RECV);
   assign slot  = (start || !slot_cnt[0]) ? SLOT_A : SLOT_B;
   assign last  = din_valid && !start && state == RECV && slot_cnt == LAST_SLOT;

   tdm_lane_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_a (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .shift_en (take && slot == SLOT_A),
      .din      (din),
      .q        (a_q),
      .q_next   (a_next)
   );

   tdm_lane_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_b (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .shift_en (take && slot == SLOT_B),
      .din      (din),
      .q        (b_q),
      .q_next   (b_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         slot_cnt  <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= start && state == RECV;
         overrun   <= 1'b0;

         if (start) begin
            state    <= RECV;
            slot_cnt <= CW'(1);
         end else if (last) begin
            state    <= IDLE;
            slot_cnt <= '0;
         end else if (take) begin
            slot_cnt <= slot_cnt + CW'(1);
         end

         // The final B bit is still in flight, so the word is taken from the lanes' next value.
         if (last) begin
            if (!out_valid || out_ready) begin
               out_a     <= a_next;
               out_b     <= b_next;
               out_valid <= 1'b1;
            end else begin
               overrun   <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux2_rx.sv
// Directed bench: LSB-first instance for scenarios 1-5, MSB-first instance for scenario 6.
module tb_tdm_demux2_rx;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, din, din_valid, sync, out_ready;
   logic [W-1:0] out_a, out_b, m_out_a, m_out_b;
   logic         out_valid, frame_err, overrun;
   logic         m_out_valid, m_frame_err, m_overrun;

   int vectors    = 0;
   int miscompares = 0;
   int err_cnt    = 0;
   int ovr_cnt    = 0;

   always #5 clk = ~clk;

   tdm_demux2_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   tdm_demux2_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .out_a(m_out_a), .out_b(m_out_b), .out_valid(m_out_valid), .out_ready(out_ready),
      .frame_err(m_frame_err), .overrun(m_overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge; tally event pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
   endtask

   task automatic idle_cycles(input int n);
      din_valid = 1'b0;
      sync      = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Sends slots first..last-1 of a frame; words are placed LSB first, sync on slot 0.
   task automatic send_slots(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int first, input int last, input bit gaps);
      for (int k = first; k < last; k++) begin
         din       = (k % 2) ? b[k/2] : a[k/2];
         sync      = (k == 0);
         din_valid = 1'b1;
         tick();
         din_valid = 1'b0;
         sync      = 1'b0;
         if (gaps && k != last - 1)
            for (int g = 0; g < (k % 3) + 1; g++) tick();
      end
   endtask

   initial begin
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_out_a",     out_a,     0);
      check("rst_out_b",     out_b,     0);
      check("rst_out_valid", out_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun",   overrun,   0);
      rst = 1'b0;
      idle_cycles(2);

      // 1: basic frame, one-cycle valid
      send_slots(8'hA5, 8'h3C, 0, 16, 1'b0);
      check("t1_valid", out_valid, 1);
      check("t1_out_a", out_a, 32'hA5);
      check("t1_out_b", out_b, 32'h3C);
      tick();
      check("t1_valid_drop", out_valid, 0);
      idle_cycles(2);

      // 2: sync-less bits ignored, gapped frame
      din = 1'b1; din_valid = 1'b1; sync = 1'b0;
      tick(); tick(); tick();
      check("t2_idle_no_valid", out_valid, 0);
      send_slots(8'hA5, 8'h3C, 0, 16, 1'b1);
      check("t2_valid", out_valid, 1);
      check("t2_out_a", out_a, 32'hA5);
      check("t2_out_b", out_b, 32'h3C);
      check("t2_no_err", err_cnt, 0);
      idle_cycles(2);

      // 3: mid-frame resync
      send_slots(8'hFF, 8'hFF, 0, 5, 1'b0);
      send_slots(8'h0F, 8'hF0, 0, 16, 1'b0);
      check("t3_err_once", err_cnt, 1);
      check("t3_out_a", out_a, 32'h0F);
      check("t3_out_b", out_b, 32'hF0);
      idle_cycles(2);

      // 4: overrun while held
      out_ready = 1'b0;
      send_slots(8'h11, 8'h22, 0, 16, 1'b0);
      check("t4_first_valid", out_valid, 1);
      send_slots(8'h33, 8'h44, 0, 16, 1'b0);
      check("t4_overrun_pulse", overrun, 1);
      check("t4_held_a", out_a, 32'h11);
      check("t4_held_b", out_b, 32'h22);
      tick();
      check("t4_overrun_once", ovr_cnt, 1);
      check("t4_still_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check("t4_accepted", out_valid, 0);
      idle_cycles(1);

      // 5: reset during slot 9
      send_slots(8'hFF, 8'hFF, 0, 9, 1'b0);
      din = 1'b1; din_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; din_valid = 1'b0;
      check("t5_rst_a",     out_a,     0);
      check("t5_rst_b",     out_b,     0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_err",   frame_err, 0);
      send_slots(8'h5A, 8'hC3, 0, 16, 1'b0);
      check("t5_valid", out_valid, 1);
      check("t5_out_a", out_a, 32'h5A);
      check("t5_out_b", out_b, 32'hC3);
      idle_cycles(2);

      // 6: MSB-first instance sees first A slot = 1 and last B slot = 1
      send_slots(8'h01, 8'h80, 0, 16, 1'b0);
      check("t6_msb_valid", m_out_valid, 1);
      check("t6_msb_a", m_out_a, 32'h80);
      check("t6_msb_b", m_out_b, 32'h01);
      check("t6_lsb_a", out_a, 32'h01);
      check("t6_lsb_b", out_b, 32'h80);
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
